// File: rtl/snap_capture_ctrl.sv
// Write-side sequencer for the snapshot BRAM: arm, optional trigger wait, then
// stream valid ADC words into port A from address 0 until the length or a stop.
module snap_capture_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  use_trig,
  input  logic                  trig,
  input  logic                  stop,
  input  logic [ADDR_WIDTH:0]   capture_len,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  bram_we,
  output logic                  bram_en_a,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state_r;
  logic [ADDR_WIDTH:0] len_r;
  logic                trig_mode_r;
  logic [ADDR_WIDTH:0] count_r;

  logic [ADDR_WIDTH:0] len_norm_s;
  logic [ADDR_WIDTH:0] count_inc_s;
  logic                go_s;
  logic                do_write_s;
  logic                finish_s;

  // Length normalisation, trigger qualification and the per-cycle write decision
  always_comb begin
    len_norm_s  = capture_len;
    count_inc_s = count_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
    go_s        = !trig_mode_r || trig;
    do_write_s  = 1'b0;
    if ((capture_len == '0) || (capture_len > DEPTH)) begin
      len_norm_s = DEPTH;
    end else begin
      len_norm_s = capture_len;
    end
    // The go cycle in ARMED writes exactly like a CAPTURE cycle unless stop/arm preempt it
    if ((state_r == CAPTURE) || ((state_r == ARMED) && !stop && !arm && go_s)) begin
      do_write_s = din_valid && (count_r < len_r);
    end else begin
      do_write_s = 1'b0;
    end
    finish_s = do_write_s && (count_inc_s == len_r);
  end

  // Capture FSM with registered status and BRAM port A outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      len_r         <= '0;
      trig_mode_r   <= 1'b0;
      count_r       <= '0;
      bram_we       <= 1'b0;
      bram_en_a     <= 1'b0;
      bram_addr     <= '0;
      bram_wr_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
    end else begin
      bram_we   <= do_write_s;
      bram_en_a <= do_write_s;
      if (do_write_s) begin
        bram_addr     <= count_r[ADDR_WIDTH-1:0];
        bram_wr_data  <= din;
        count_r       <= count_inc_s;
        words_written <= count_inc_s;
      end

      case (state_r)
        IDLE, DONE: begin
          if (arm) begin
            state_r       <= ARMED;
            len_r         <= len_norm_s;
            trig_mode_r   <= use_trig;
            count_r       <= '0;
            words_written <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
          end
        end
        ARMED: begin
          if (stop) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (arm) begin
            len_r       <= len_norm_s;
            trig_mode_r <= use_trig;
          end else if (go_s) begin
            if (finish_s) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          // arm is deliberately ignored here; only stop or a full count end the capture
          if (stop || finish_s) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
